// File: rtl/train_segment_tracker.sv
// Synchronises N track sensors, follows the train sensor to sensor, times and predicts segments.
// Optional overspeed flag (min_time input, overspeed output) when TRACKER_OVERSPEED_EN is defined.
module train_segment_tracker #(
  parameter int N_SENSORS   = 6,
  parameter int TIME_W      = 15,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_SENSORS-1:0]         sens_in,
  input  logic                         clear_fault,
`ifdef TRACKER_OVERSPEED_EN
  input  logic [TIME_W-1:0]            min_time,
  output logic                         overspeed,
`endif
  output logic [TIME_W-1:0]            seg_time,
  output logic [TIME_W-1:0]            pred_time,
  output logic                         seg_valid,
  output logic [$clog2(N_SENSORS)-1:0] position,
  output logic                         dir,
  output logic                         busy,
  output logic                         lap_done,
  output logic                         fault,
  output logic [6:0]                   seg7
);

  localparam int IDX_W = $clog2(N_SENSORS);
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TIME_W-1:0] T_MAX = {TIME_W{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t                 state, state_next;
  logic [N_SENSORS-1:0]   sens_sync [SYNC_STAGES];
  logic [N_SENSORS-1:0]   sens_dly;
  logic [N_SENSORS-1:0]   edge_p0;
  logic [PW-1:0]          presc;
  logic [TIME_W-1:0]      timer, timer_now, prev_seg;
  logic                   hist_vld, tick;
  logic [IDX_W-1:0]       expected;
  logic [N_SENSORS-1:0]   exp_mask;
  logic                   at_end, start_fwd, start_rev, accept;

  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] t);
    return (t == T_MAX) ? t : t + TIME_W'(1);
  endfunction

  // Average with one extra bit so the sum cannot overflow before the shift.
  function automatic logic [TIME_W-1:0] avg2(input logic [TIME_W-1:0] a, input logic [TIME_W-1:0] b);
    logic [TIME_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[TIME_W:1];
  endfunction

  function automatic logic [6:0] seg7_of(input logic [IDX_W-1:0] p);
    case (4'(p))
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0101010;
    endcase
  endfunction

  // Input stage: synchroniser chain, then registered rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sens_sync[i] <= '0;
      sens_dly <= '0;
      edge_p0  <= '0;
    end else begin
      sens_sync[0] <= sens_in;
      for (int i = 1; i < SYNC_STAGES; i++) sens_sync[i] <= sens_sync[i-1];
      sens_dly <= sens_sync[SYNC_STAGES-1];
      edge_p0  <= sens_sync[SYNC_STAGES-1] & ~sens_dly;
    end
  end

  assign tick      = (state == RUN) && (presc == PW'(TICK_DIV - 1));
  assign timer_now = tick ? sat_inc(timer) : timer;
  assign exp_mask  = N_SENSORS'(1) << expected;
  assign at_end    = dir ? (expected == '0) : (expected == IDX_W'(N_SENSORS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_fwd  = 1'b0;
    start_rev  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (edge_p0[0]) begin
          start_fwd  = 1'b1;
          state_next = RUN;
        end else if (edge_p0[N_SENSORS-1]) begin
          start_rev  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (|(edge_p0 & ~exp_mask)) begin
          state_next = FAULT;
        end else if (|(edge_p0 & exp_mask)) begin
          accept = 1'b1;
          if (at_end) state_next = IDLE;
        end else if (timer_now == T_MAX) begin
          state_next = FAULT;
        end
      end
      FAULT:   if (clear_fault) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state == RUN);
  assign fault = (state == FAULT);

  // Timing, tracking and result registers; the timer freezes outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      timer     <= '0;
      prev_seg  <= '0;
      hist_vld  <= 1'b0;
      expected  <= '0;
      dir       <= 1'b0;
      position  <= '0;
      seg_time  <= '0;
      pred_time <= '0;
      seg_valid <= 1'b0;
      lap_done  <= 1'b0;
      seg7      <= 7'b1000000;
    end else begin
      seg_valid <= accept;
      lap_done  <= accept && at_end;
      seg7      <= seg7_of(position);
      if (start_fwd || start_rev || accept) begin
        presc <= '0;
        timer <= '0;
      end else if (state == RUN) begin
        presc <= tick ? '0 : presc + PW'(1);
        timer <= timer_now;
      end
      if (start_fwd) begin
        dir      <= 1'b0;
        expected <= IDX_W'(1);
        position <= '0;
        hist_vld <= 1'b0;
      end else if (start_rev) begin
        dir      <= 1'b1;
        expected <= IDX_W'(N_SENSORS - 2);
        position <= IDX_W'(N_SENSORS - 1);
        hist_vld <= 1'b0;
      end else if (accept) begin
        position  <= expected;
        seg_time  <= timer_now;
        pred_time <= hist_vld ? avg2(timer_now, prev_seg) : timer_now;
        prev_seg  <= timer_now;
        hist_vld  <= 1'b1;
        if (!at_end) expected <= dir ? expected - IDX_W'(1) : expected + IDX_W'(1);
      end
    end
  end

`ifdef TRACKER_OVERSPEED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      overspeed <= 1'b0;
    else if (accept) overspeed <= (timer_now < min_time);
  end
`endif

endmodule

// File: tb/tb_train_segment_tracker.sv
// Scoreboard bench for train_segment_tracker: runs, reversal, faults, timeout, reset abort.
module tb_train_segment_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  sens, sens_b;
  logic        clear_fault, clear_b;
  logic [14:0] seg_time, pred_time;
  logic        seg_valid, dir, busy, lap_done, fault;
  logic [2:0]  position;
  logic [6:0]  seg7;
  logic [3:0]  seg_time_b, pred_time_b;
  logic        seg_valid_b, dir_b, busy_b, lap_done_b, fault_b;
  logic [2:0]  position_b;
  logic [6:0]  seg7_b;
`ifdef TRACKER_OVERSPEED_EN
  logic [14:0] min_time = 15'd12;
  logic [3:0]  min_time_b = 4'd0;
  logic        overspeed, overspeed_b;
`endif

  typedef struct { int seg; int pred; bit lap; } exp_t;
  exp_t sb[$];
  int   errs = 0, checks = 0;
  int   m_prev = 0;
  bit   m_hist = 0;

  always #5 clk = ~clk;

  train_segment_tracker #(.N_SENSORS(6), .TIME_W(15), .SYNC_STAGES(2), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .sens_in(sens), .clear_fault(clear_fault),
`ifdef TRACKER_OVERSPEED_EN
    .min_time(min_time), .overspeed(overspeed),
`endif
    .seg_time(seg_time), .pred_time(pred_time), .seg_valid(seg_valid), .position(position),
    .dir(dir), .busy(busy), .lap_done(lap_done), .fault(fault), .seg7(seg7));

  train_segment_tracker #(.N_SENSORS(6), .TIME_W(4), .SYNC_STAGES(2), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sens_in(sens_b), .clear_fault(clear_b),
`ifdef TRACKER_OVERSPEED_EN
    .min_time(min_time_b), .overspeed(overspeed_b),
`endif
    .seg_time(seg_time_b), .pred_time(pred_time_b), .seg_valid(seg_valid_b), .position(position_b),
    .dir(dir_b), .busy(busy_b), .lap_done(lap_done_b), .fault(fault_b), .seg7(seg7_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One-cycle pin pulse on every sensor in mask; next stimulus starts gap clocks later.
  task automatic hit(input logic [5:0] mask, input int gap);
    sens = mask;
    @(posedge clk); #1;
    sens = '0;
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  task automatic expect_seg(input int seg, input bit lap);
    exp_t e;
    e.seg  = seg;
    e.pred = m_hist ? (seg + m_prev) / 2 : seg;
    e.lap  = lap;
    m_prev = seg;
    m_hist = 1;
    sb.push_back(e);
  endtask

  task automatic pulse_clear;
    clear_fault = 1'b1;
    @(posedge clk); #1;
    clear_fault = 1'b0;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && seg_valid) begin
      if (sb.size() == 0) begin
        chk("sb_extra_valid", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("seg_time", 32'(seg_time), 32'(e.seg));
        chk("pred_time", 32'(pred_time), 32'(e.pred));
        chk("lap_done", 32'(lap_done), 32'(e.lap));
`ifdef TRACKER_OVERSPEED_EN
        chk("overspeed", 32'(overspeed), 32'(e.seg < 12));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps[5] = '{40, 80, 40, 40, 40};
    rst_n = 1'b0; sens = '0; sens_b = '0; clear_fault = 1'b0; clear_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg7", 32'(seg7), 32'b1000000);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_pos", 32'(position), 32'd0);
    chk("rst_valid", 32'(seg_valid), 32'd0);
    chk("rst_pred", 32'(pred_time), 32'd0);
`ifdef TRACKER_OVERSPEED_EN
    chk("rst_overspeed", 32'(overspeed), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Forward lap 0..5
    m_hist = 0;
    hit(6'b000001, gaps[0]);
    chk("fwd_busy", 32'(busy), 32'd1);
    chk("fwd_dir", 32'(dir), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      expect_seg(gaps[i-1] / 4, i == 5);
      hit(6'(1 << i), (i < 5) ? gaps[i] : 10);
    end
    chk("lap_idle", 32'(busy), 32'd0);
    chk("lap_pos", 32'(position), 32'd5);
    chk("lap_seg7", 32'(seg7), 32'b0010010);
    chk("lap_fault", 32'(fault), 32'd0);

    // Reverse start, one segment, then stray sensor 0 faults
    m_hist = 0;
    hit(6'b100000, 40);
    expect_seg(10, 0);
    hit(6'b010000, 20);
    chk("rev_dir", 32'(dir), 32'd1);
    chk("rev_pos", 32'(position), 32'd4);
    chk("rev_seg7", 32'(seg7), 32'b0011001);
    chk("rev_busy", 32'(busy), 32'd1);
    hit(6'b000001, 10);
    chk("rev_fault", 32'(fault), 32'd1);
    pulse_clear();
    chk("rev_clear", 32'(fault), 32'd0);

    // Out-of-order: 0, 1, then 3
    m_hist = 0;
    hit(6'b000001, 40);
    expect_seg(10, 0);
    hit(6'b000010, 40);
    hit(6'b001000, 10);
    chk("ooo_fault", 32'(fault), 32'd1);
    chk("ooo_busy", 32'(busy), 32'd0);
    chk("ooo_hold", 32'(seg_time), 32'd10);
    hit(6'b000100, 10);
    chk("fault_ign_edge", 32'(fault), 32'd1);
    pulse_clear();
    chk("ooo_clear", 32'(fault), 32'd0);
    chk("ooo_idle", 32'(busy), 32'd0);

    // Simultaneous edges: IDLE tie goes forward; expected plus other in RUN faults
    hit(6'b100001, 40);
    chk("sim_dir", 32'(dir), 32'd0);
    chk("sim_pos", 32'(position), 32'd0);
    chk("sim_busy", 32'(busy), 32'd1);
    hit(6'b000110, 10);
    chk("sim_fault", 32'(fault), 32'd1);
    pulse_clear();
    chk("sim_clear", 32'(fault), 32'd0);

    // Reset mid-run aborts, next run starts with fresh history
    hit(6'b000001, 40);
    expect_seg(10, 0);
    hit(6'b000010, 20);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_seg7", 32'(seg7), 32'b1000000);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_seg", 32'(seg_time), 32'd0);
    chk("mrst_pred", 32'(pred_time), 32'd0);
    chk("mrst_pos", 32'(position), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_hist = 0;
    hit(6'b000001, 80);
    expect_seg(20, 0);
    hit(6'b000010, 20);
    chk("fresh_pos", 32'(position), 32'd1);

    // Timeout on the 4-bit, undivided instance
    sens_b = 6'b000001;
    @(posedge clk); #1;
    sens_b = '0;
    repeat (10) @(posedge clk);
    #1;
    chk("to_busy_early", 32'(busy_b), 32'd1);
    chk("to_fault_early", 32'(fault_b), 32'd0);
    for (int i = 0; i < 40 && !fault_b; i++) @(posedge clk);
    #1;
    chk("to_fault", 32'(fault_b), 32'd1);
    chk("to_busy", 32'(busy_b), 32'd0);
    clear_b = 1'b1;
    @(posedge clk); #1;
    clear_b = 1'b0;
    chk("to_clear", 32'(fault_b), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/train_segment_tracker.md
Name: train_segment_tracker

Overview:
- Parametrised successor to the fixed six-sensor train controller path (synchroniser, time measurement, predictor, 7-seg display), generalised to N track sensors and selectable direction.
- Synchronises N asynchronous track sensors and tracks the train sensor to sensor with an FSM.
- Measures each segment's transit time in prescaled ticks, predicts the next segment time, and flags out-of-order sensors and timeouts.
- Sits between the raw sensor pins and the controller/display logic.

Parameters:
- N_SENSORS, 6, number of track sensors; legal range 2..10.
- TIME_W, 15, width of segment timer and time outputs.
- SYNC_STAGES, 2, synchroniser flops per sensor; minimum 2.
- TICK_DIV, 1000, clocks per timer tick; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sens_in  in  N_SENSORS  raw asynchronous sensor inputs, active-high.
- clear_fault  in  1  single-cycle pulse; leaves FAULT.
- seg_time  out  TIME_W  last measured segment time in ticks.
- pred_time  out  TIME_W  predicted time of the next segment.
- seg_valid  out  1  one-cycle pulse when seg_time/pred_time update.
- position  out  IDX_W  index of the last sensor hit; IDX_W = $clog2(N_SENSORS).
- dir  out  1  0 = forward (ascending index), 1 = reverse.
- busy  out  1  high in RUN.
- lap_done  out  1  one-cycle pulse when the end sensor is reached.
- fault  out  1  high in FAULT.
- seg7  out  7  active-low segment pattern for position.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0 and FSM in IDLE;
  - seg7 = 7'b1000000 (digit 0);
  - timer, prescaler and synchroniser flops cleared.
- Input path:
  - each sensor passes through SYNC_STAGES flops, then a rising-edge detector (sync_q & ~sync_q_d);
  - an edge is a one-cycle event;
  - latency from pin to event is SYNC_STAGES+1 cycles.
- Prescaler:
  - counts 0..TICK_DIV-1 and emits a tick on wrap;
  - runs only in RUN and is cleared on entering RUN and on each accepted segment.
- Timer:
  - increments on tick and saturates at 2^TIME_W-1;
  - reaching saturation in RUN is a timeout.
- FSM IDLE:
  - edge on sensor 0: dir = 0, expected = 1, position = 0, go RUN.
  - otherwise, edge on sensor N-1: dir = 1, expected = N-2, position = N-1, go RUN.
  - Sensor 0 wins if both edge together. Other edges are ignored.
  - Entering RUN clears the timer and the history-valid flag.
- FSM RUN, edge on the expected sensor only:
  - seg_time = timer; position = expected; seg_valid pulses next cycle; timer cleared.
  - pred_time = seg_time if no previous segment in this run, else (seg_time + prev_seg_time) >> 1, computed with a TIME_W+1-bit sum.
  - prev_seg_time = seg_time.
  - If expected is the end sensor (N-1 forward, 0 reverse): lap_done pulses together with seg_valid and the FSM returns to IDLE.
  - Otherwise expected advances by +1 or -1 according to dir.
- FSM RUN, go FAULT and hold seg_time/pred_time when any of these occurs:
  - an edge on any non-expected sensor, including one simultaneous with the expected sensor;
  - a timeout.
- FSM FAULT:
  - fault = 1; busy = 0; edges ignored; timer frozen.
  - clear_fault returns to IDLE and clears fault the next cycle.
  - clear_fault is ignored in other states.
- Outputs:
  - busy = (state == RUN).
  - seg7 is registered from position:
    - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001,
    - 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000,
    - default 0101010.
- Reset mid-run aborts immediately to the reset values above; the next run starts fresh.

Optional Feature:
- Macro TRACKER_OVERSPEED_EN.
- When defined, it adds:
  - input min_time [TIME_W-1:0];
  - output overspeed (1 bit, reset 0).
- overspeed is set in the seg_valid cycle when seg_time < min_time. It stays set until the next seg_valid with seg_time >= min_time, or until reset.
- When undefined, neither port exists and behaviour is unchanged.

Test Plan:
- Reset, then forward run with N=6, TICK_DIV=4: edges on sensors 0..5 spaced 40, 80, 40, 40, 40 clocks after sync.
  - Expected seg_time = 10, 20, 10, 10, 10.
  - Expected pred_time = 10, 15, 15, 10, 10.
  - lap_done pulses with the fifth seg_valid; FSM returns to IDLE; position = 5; seg7 = 0010010.
- Reverse run: edges on sensors 5 then 4 → dir = 1, position = 4, seg7 = 0011001.
- Out-of-order: forward run, after sensor 1, edge on sensor 3 → fault = 1, busy = 0, seg_time held.
  - clear_fault → IDLE, fault = 0.
- Timeout, TIME_W=4, TICK_DIV=1: after the start edge, no further edge for 15 ticks → fault = 1.
- Simultaneous events: sensors 0 and 5 edge together in IDLE → dir = 0.
  - In RUN, expected and one other sensor edge together → FAULT.
- Assert rst_n low mid-run → all outputs 0 and seg7 = 1000000 immediately.
  - With TRACKER_OVERSPEED_EN and min_time = 12: a seg_time of 10 sets overspeed; a following seg_time of 20 clears it.
